evt_qualifier: RTL and testbench
================================

# evt_qualifier

Debugger front-end stage that turns a raw multi-bit probe into the single-cycle `evt_in` strobe consumed by the event counter. It samples a probe bus, applies a mask/match comparison, and detects the rising edge of the match condition. It gates the result through an arm/holdoff state machine, so one physical occurrence yields exactly one counted event. Rejected occurrences during holdoff are tallied separately for the debug readout.

## Interface
Parameters:
- `WIDTH`, 8 — probe bus width (≥1).
- `HOLDOFF_CYCLES`, 16 — cycles of event suppression after each accepted event (≥0).
- `DROP_MAX`, 256 — drop counter range; counter width is `$clog2(DROP_MAX)`.

Ports:
- `clk_in`  in  1  — system clock; the only clock.
- `rst_in`  in  1  — reset, synchronous, active-high.
- `arm_in`  in  1  — level/pulse; moves IDLE→ARMED.
- `disarm_in`  in  1  — forces IDLE from any state.
- `sig_in`  in  WIDTH  — raw probe bus.
- `mask_in`  in  WIDTH  — 1 = bit participates in compare.
- `match_in`  in  WIDTH  — compare value.
- `evt_out`  out  1  — single-cycle qualified event; drives event counter `evt_in`.
- `armed_out`  out  1  — high in ARMED or HOLDOFF.
- `holdoff_out`  out  1  — high in HOLDOFF.
- `drop_count_out`  out  `$clog2(DROP_MAX)`  — saturating count of suppressed edges.

## Operation
- Sample stage: `sig_q <= sig_in` every cycle.
- `hit = ((sig_q ^ match_in) & mask_in) == 0` (combinational).
- `hit_prev <= hit` every cycle, in every state.
- `rise = hit & ~hit_prev`.
- State machine, held in a register:
  - IDLE: `arm_in` → ARMED. Rises are ignored and not counted as drops.
  - ARMED: on `rise`: `evt_out <= 1`. If `HOLDOFF_CYCLES>0`, go to HOLDOFF with `hold_cnt <= HOLDOFF_CYCLES-1`; otherwise stay ARMED.
  - HOLDOFF: if `hold_cnt==0` → ARMED, else `hold_cnt <= hold_cnt-1`. A `rise` here increments `drop_count_out`.
- `drop_count_out` saturates at `DROP_MAX-1`. It never wraps.
- `disarm_in` goes to IDLE from any state and clears `hold_cnt`; it beats `arm_in` when both are asserted. `drop_count_out` is retained.
- `arm_in` in ARMED or HOLDOFF is ignored.
- `mask_in = 0` makes `hit` constantly 1, so no event ever fires.
- Arming while `hit` is already high does not fire; a fresh 0→1 transition is required.
- Only `rst_in` clears `drop_count_out`.

## Timing
- Reset values:
  - state IDLE.
  - `sig_q = 0`, `hit_prev = 1`.
  - `evt_out = 0`, `armed_out = 0`, `holdoff_out = 0`.
  - `hold_cnt = 0`, `drop_count_out = 0`.
- Setting `hit_prev` to 1 at reset prevents a spurious event after reset.
- Latency: `sig_in` change set up before edge t → `sig_q` at t → `evt_out` high for exactly one cycle after edge t+1.
- `evt_out` is never high on two consecutive cycles.
- Arming:
  - `arm_in` sampled at edge t → ARMED after t.
  - A rise evaluated at edge t+1 qualifies; one evaluated at edge t does not.
- Holdoff:
  - Event accepted at edge e → rises at edges e+1 … e+HOLDOFF_CYCLES are dropped.
  - The first eligible edge is e+HOLDOFF_CYCLES+1.
- `armed_out` and `holdoff_out` are registered state decodes; they change on the same edge as the state.
- Reset asserted mid-HOLDOFF: all registers return to reset values on that edge, and any pending `evt_out` is cleared.
- Disarm and rise at the same edge: disarm wins, with no `evt_out` and no drop.

## Configuration
- `EVT_QUALIFIER_SYNC_EN` defined:
  - `sig_in` passes through a 2-flop synchronizer (reset to 0) before `sig_q`, for asynchronous probes.
  - Total latency becomes 4 cycles: change before edge t → `evt_out` high after edge t+3.
- Undefined: no synchronizer; latency as specified in Timing.
- Either way, `hit_prev` is forced to 1 until the pipeline has refilled after reset.

## Test plan
- Reset, `arm_in`=1 for 1 cycle, `mask=0xFF`, `match=0xA5`, drive `sig_in=0xA5` → one `evt_out` pulse, 2 cycles after the drive edge. `armed_out=1`, `holdoff_out=1` for 16 cycles.
- `HOLDOFF_CYCLES=4`, toggle `sig_in` 0x00↔0xA5 every 2 cycles for 40 cycles → events spaced ≥5 edges apart; `drop_count_out` equals the number of rises inside holdoff windows.
- `mask=0x0F`, `match=0x05`, `sig_in` 0x00→0xF5 → event fires (upper nibble ignored). `mask=0x00` with any toggling → no event ever.
- Hold `sig_in=match` while IDLE, then arm → no event. Drop to 0, then back to match → one event.
- `DROP_MAX=4`, 10 rises during a long holdoff → `drop_count_out` stops at 3. `disarm_in` keeps it at 3; `rst_in` clears it to 0.
- Assert `arm_in` and `disarm_in` together in IDLE → stays IDLE. Apply `rst_in` mid-HOLDOFF → all outputs 0 on the next cycle, and no event fires until re-armed.

Source files
------------

// File: rtl/evt_qualifier.sv
// evt_qualifier: turns a raw probe bus into a single-cycle qualified event.
//   probe -> sample register -> mask/match compare -> rising-edge detect
//   -> arm/holdoff state machine -> evt_out
// Suppressed edges that land inside a holdoff window are tallied in a
// saturating drop counter that only rst_in clears.
//
// Optional build macro: EVT_QUALIFIER_SYNC_EN
//   When defined, sig_in first passes through a 2-flop synchronizer so
//   asynchronous probes can be attached; input-to-event latency grows by 2.
//
// state_dbg_out exposes the raw state register for debug and checkers:
//   2'b00 IDLE, 2'b01 ARMED, 2'b10 HOLDOFF.

module evt_qualifier #(
  parameter int WIDTH          = 8,
  parameter int HOLDOFF_CYCLES = 16,
  parameter int DROP_MAX       = 256,
  localparam int DCW           = (DROP_MAX > 1) ? $clog2(DROP_MAX) : 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             arm_in,
  input  logic             disarm_in,
  input  logic [WIDTH-1:0] sig_in,
  input  logic [WIDTH-1:0] mask_in,
  input  logic [WIDTH-1:0] match_in,
  output logic             evt_out,
  output logic             armed_out,
  output logic             holdoff_out,
  output logic [DCW-1:0]   drop_count_out,
  output logic [1:0]       state_dbg_out
);

  // Holdoff down-counter only ever holds values 0 .. HOLDOFF_CYCLES-1.
  localparam int HCW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [HCW-1:0] HOLD_INIT =
    HCW'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);
  localparam logic [DCW-1:0] DROP_SAT =
    DCW'((DROP_MAX > 1) ? DROP_MAX - 1 : 0);

  // Number of edges after reset before sig_q holds a real probe sample.
`ifdef EVT_QUALIFIER_SYNC_EN
  localparam logic [1:0] FILL = 2'd3;
`else
  localparam logic [1:0] FILL = 2'd1;
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_HOLDOFF = 2'b10
  } state_t;

  state_t           state_q;
  logic [HCW-1:0]   hold_cnt_q;
  logic             evt_q;
  logic             armed_q;
  logic             holdoff_q;
  logic [DCW-1:0]   drop_q;

  logic [WIDTH-1:0] sig_q;
  logic [1:0]       fill_q;
  logic             hit_prev_q;
  logic             hit_prev_d;
  logic             pipe_full;
  logic             hit;
  logic             rise;

`ifdef EVT_QUALIFIER_SYNC_EN
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  // Two-flop synchronizer in front of the sample register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
    end
  end
`endif

  // Compare the sampled probe against the masked match value.
  assign hit       = (((sig_q ^ match_in) & mask_in) == '0);
  assign rise      = hit & ~hit_prev_q;
  assign pipe_full = (fill_q == FILL);

  // Until real samples reach sig_q the previous-hit history is pinned high,
  // so reset-value data can never manufacture a rising edge.
  always_comb begin
    hit_prev_d = 1'b1;
    if (pipe_full) begin
      hit_prev_d = hit;
    end
  end

  // Sample register, pipeline fill tracking and previous-hit history.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sig_q      <= '0;
      fill_q     <= '0;
      hit_prev_q <= 1'b1;
    end else begin
`ifdef EVT_QUALIFIER_SYNC_EN
      sig_q <= sync2_q;
`else
      sig_q <= sig_in;
`endif
      if (!pipe_full) begin
        fill_q <= fill_q + 2'd1;
      end
      hit_prev_q <= hit_prev_d;
    end
  end

  // Arm/holdoff state machine with registered event, status and drop count.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      evt_q      <= 1'b0;
      armed_q    <= 1'b0;
      holdoff_q  <= 1'b0;
      drop_q     <= '0;
    end else begin
      evt_q <= 1'b0;
      if (disarm_in) begin
        // Disarm overrides arm and any coincident rise; drops are kept.
        state_q    <= ST_IDLE;
        hold_cnt_q <= '0;
        armed_q    <= 1'b0;
        holdoff_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (arm_in) begin
              state_q <= ST_ARMED;
              armed_q <= 1'b1;
            end
          end
          ST_ARMED: begin
            if (rise) begin
              evt_q <= 1'b1;
              if (HOLDOFF_CYCLES > 0) begin
                state_q    <= ST_HOLDOFF;
                hold_cnt_q <= HOLD_INIT;
                holdoff_q  <= 1'b1;
              end
            end
          end
          ST_HOLDOFF: begin
            if (hold_cnt_q == '0) begin
              state_q   <= ST_ARMED;
              holdoff_q <= 1'b0;
            end else begin
              hold_cnt_q <= hold_cnt_q - HCW'(1);
            end
            if (rise && (drop_q != DROP_SAT)) begin
              drop_q <= drop_q + DCW'(1);
            end
          end
          default: begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            armed_q    <= 1'b0;
            holdoff_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign evt_out        = evt_q;
  assign armed_out      = armed_q;
  assign holdoff_out    = holdoff_q;
  assign drop_count_out = drop_q;
  assign state_dbg_out  = state_q;

endmodule

// File: tb/tb_evt_qualifier.sv
// Testbench for evt_qualifier. Three instances share one stimulus stream:
//   a: defaults (holdoff 16, drop range 256)
//   b: holdoff 4, drop range 4 (saturation at 3)
//   c: holdoff 0 (never leaves ARMED on an event), drop range 8
// The reference model tracks, per instance, an armed flag and the last edge
// index still inside the holdoff window; rises are derived from a history of
// sampled probe values.

module tb_evt_qualifier;

`ifdef EVT_QUALIFIER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  // ---------------- clock / reset / shared inputs ----------------
  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       arm_in;
  logic       disarm_in;
  logic [7:0] sig_in;
  logic [7:0] mask_in;
  logic [7:0] match_in;

  always #5 clk_in = ~clk_in;

  logic       evt_a, armed_a, hold_a;
  logic [7:0] drop_a;
  logic [1:0] st_a;
  logic       evt_b, armed_b, hold_b;
  logic [1:0] drop_b;
  logic [1:0] st_b;
  logic       evt_c, armed_c, hold_c;
  logic [2:0] drop_c;
  logic [1:0] st_c;

  evt_qualifier #(.WIDTH(8)) u_dut_a (
    .clk_in(clk_in), .rst_in(rst_in), .arm_in(arm_in), .disarm_in(disarm_in),
    .sig_in(sig_in), .mask_in(mask_in), .match_in(match_in),
    .evt_out(evt_a), .armed_out(armed_a), .holdoff_out(hold_a),
    .drop_count_out(drop_a), .state_dbg_out(st_a)
  );

  evt_qualifier #(.WIDTH(8), .HOLDOFF_CYCLES(4), .DROP_MAX(4)) u_dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .arm_in(arm_in), .disarm_in(disarm_in),
    .sig_in(sig_in), .mask_in(mask_in), .match_in(match_in),
    .evt_out(evt_b), .armed_out(armed_b), .holdoff_out(hold_b),
    .drop_count_out(drop_b), .state_dbg_out(st_b)
  );

  evt_qualifier #(.WIDTH(8), .HOLDOFF_CYCLES(0), .DROP_MAX(8)) u_dut_c (
    .clk_in(clk_in), .rst_in(rst_in), .arm_in(arm_in), .disarm_in(disarm_in),
    .sig_in(sig_in), .mask_in(mask_in), .match_in(match_in),
    .evt_out(evt_c), .armed_out(armed_c), .holdoff_out(hold_c),
    .drop_count_out(drop_c), .state_dbg_out(st_c)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int  P_H[3]    = '{16, 4, 0};
  int  P_DMAX[3] = '{256, 4, 8};

  int  n;                       // edges since the last reset edge
  logic [7:0] sig_hist [0:8191];
  bit         h_hist   [0:8191];
  bit  m_armed [3];
  int  m_block [3];             // last edge index whose rise is dropped
  int  m_drop  [3];
  bit  m_evt   [3];
  bit  prev_evt [3];

  logic [31:0] exp_q[$];        // expected event edges of instance b

  task automatic model_edge();
    logic [12:0] ix;
    logic [12:0] ixp;
    bit h;
    bit rise;
    if (rst_in) begin
      n = 0;
      for (int d = 0; d < 3; d++) begin
        m_armed[d] = 1'b0;
        m_block[d] = -1;
        m_drop[d]  = 0;
        m_evt[d]   = 1'b0;
      end
    end else begin
      n++;
      ix = 13'(n);
      sig_hist[ix] = sig_in;
      h = 1'b1;
      if (n - LAT >= 1) begin
        ixp = 13'(n - LAT);
        h = (((sig_hist[ixp] ^ match_in) & mask_in) == 8'h00);
      end
      h_hist[ix] = h;
      ixp  = 13'(n - 1);
      rise = h && (n - 1 >= LAT + 1) && !h_hist[ixp];
      for (int d = 0; d < 3; d++) begin
        m_evt[d] = 1'b0;
        if (disarm_in) begin
          m_armed[d] = 1'b0;
          m_block[d] = -1;
        end else if (!m_armed[d]) begin
          if (arm_in) begin
            m_armed[d] = 1'b1;
            m_block[d] = n;
          end
        end else if (rise) begin
          if (n <= m_block[d]) begin
            if (m_drop[d] < P_DMAX[d] - 1) m_drop[d]++;
          end else begin
            m_evt[d]   = 1'b1;
            m_block[d] = n + P_H[d];
            if (d == 1) exp_q.push_back(32'(n));
          end
        end
      end
    end
  endtask

  function automatic bit exp_hold(input int d);
    return m_armed[d] && (n < m_block[d]);
  endfunction

  task automatic compare_all();
    check("a_evt",   evt_a,   m_evt[0]);
    check("a_armed", armed_a, m_armed[0]);
    check("a_hold",  hold_a,  exp_hold(0));
    check("a_drop",  drop_a,  m_drop[0]);
    check("b_evt",   evt_b,   m_evt[1]);
    check("b_armed", armed_b, m_armed[1]);
    check("b_hold",  hold_b,  exp_hold(1));
    check("b_drop",  drop_b,  m_drop[1]);
    check("c_evt",   evt_c,   m_evt[2]);
    check("c_armed", armed_c, m_armed[2]);
    check("c_hold",  hold_c,  exp_hold(2));
    check("c_drop",  drop_c,  m_drop[2]);
    check("a_evt_2x", prev_evt[0] & evt_a, 0);
    check("b_evt_2x", prev_evt[1] & evt_b, 0);
    prev_evt[0] = evt_a;
    prev_evt[1] = evt_b;
    prev_evt[2] = evt_c;
    // Scoreboard for instance b: every observed event must be the next expected one.
    if (evt_b) begin
      if (exp_q.size() == 0) check("b_sb_unexp", evt_b, 0);
      else check("b_sb_edge", 32'(n), exp_q.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_in);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic pulse_arm();
    arm_in = 1'b1;
    step();
    arm_in = 1'b0;
  endtask

  task automatic pulse_disarm();
    disarm_in = 1'b1;
    step();
    disarm_in = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_in = 1'b1; arm_in = 1'b0; disarm_in = 1'b0;
    sig_in = 8'h00; mask_in = 8'hFF; match_in = 8'hA5;
    for (int d = 0; d < 3; d++) prev_evt[d] = 1'b0;
    repeat (3) step();
    check("a_drop_rst0", drop_a, 0);
    rst_in = 1'b0;
    repeat (5) step();

    // Basic event and holdoff window
    pulse_arm();
    repeat (3) step();
    sig_in = 8'hA5;
    step(); step();
    check("a_tp1_evt", evt_a, 1);
    step();
    check("a_tp1_hold", hold_a, 1);
    repeat (20) step();

    // Toggle every 2 cycles for 40 cycles
    for (int i = 0; i < 20; i++) begin
      sig_in = (sig_in == 8'hA5) ? 8'h00 : 8'hA5;
      step(); step();
    end

    // Nibble mask: upper bits ignored
    mask_in = 8'h0F; match_in = 8'h05; sig_in = 8'h00;
    repeat (20) step();
    sig_in = 8'hF5;
    step(); step();
    check("a_nib_evt", evt_a, 1);
    check("c_nib_evt", evt_c, 1);
    // Empty mask with random toggling
    mask_in = 8'h00;
    for (int i = 0; i < 30; i++) begin
      sig_in = 8'($urandom);
      step();
    end

    // Arming while already matching does not fire
    mask_in = 8'hFF; match_in = 8'hA5; sig_in = 8'hA5;
    pulse_disarm();
    repeat (5) step();
    pulse_arm();
    repeat (5) step();
    check("a_arm_quiet", evt_a, 0);
    sig_in = 8'h00;
    repeat (3) step();
    sig_in = 8'hA5;
    step(); step();
    check("a_rearm_evt", evt_a, 1);
    repeat (20) step();

    // Drop saturation, retained over disarm
    for (int i = 0; i < 40; i++) begin
      sig_in = (sig_in == 8'hA5) ? 8'h00 : 8'hA5;
      step();
    end
    check("b_drop_sat", drop_b, 3);
    pulse_disarm();
    check("b_drop_keep", drop_b, 3);

    // Arm and disarm together in IDLE
    arm_in = 1'b1; disarm_in = 1'b1;
    step();
    check("a_armdis", armed_a, 0);
    arm_in = 1'b0; disarm_in = 1'b0;
    step();

    // Reset in the middle of holdoff
    sig_in = 8'h00;
    pulse_arm();
    repeat (3) step();
    sig_in = 8'hA5;
    repeat (4) step();
    check("a_pre_rst_hold", hold_a, 1);
    rst_in = 1'b1;
    step();
    check("a_rst_hold", hold_a, 0);
    check("a_rst_armed", armed_a, 0);
    check("a_rst_drop", drop_a, 0);
    check("b_drop_rst", drop_b, 0);
    rst_in = 1'b0;
    repeat (6) step();
    for (int i = 0; i < 10; i++) begin
      sig_in = (sig_in == 8'hA5) ? 8'h00 : 8'hA5;
      step();
      check("a_noarm_evt", evt_a, 0);
    end

    // Randomized run
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = int'($urandom_range(0, 199));
      rst_in    = (r == 0);
      arm_in    = (r >= 1 && r <= 16);
      disarm_in = (r >= 190 && r <= 194);
      if ($urandom_range(0, 99) < 2) begin
        case ($urandom_range(0, 3))
          0: mask_in = 8'hFF;
          1: mask_in = 8'h0F;
          2: mask_in = 8'hF0;
          default: mask_in = 8'($urandom);
        endcase
      end
      if ($urandom_range(0, 99) < 2) match_in = 8'($urandom);
      if ($urandom_range(0, 1) == 1) sig_in = match_in;
      else sig_in = 8'($urandom);
      step();
    end
    rst_in = 1'b0; arm_in = 1'b0; disarm_in = 1'b0;
    repeat (3) step();

    check("b_sb_left", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
